// File: rtl/charis_pkg.sv
// Shared opcode/func constants, ALU encodings and FSM types for the CHARIS control path.
package charis_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b100000;
    localparam logic [5:0] OP_LI    = 6'b111000;
    localparam logic [5:0] OP_LUI   = 6'b111001;
    localparam logic [5:0] OP_ADDI  = 6'b110000;
    localparam logic [5:0] OP_ANDI  = 6'b110010;
    localparam logic [5:0] OP_ORI   = 6'b110011;
    localparam logic [5:0] OP_B     = 6'b111111;
    localparam logic [5:0] OP_BEQ   = 6'b000000;
    localparam logic [5:0] OP_BNE   = 6'b000001;
    localparam logic [5:0] OP_LB    = 6'b000011;
    localparam logic [5:0] OP_SB    = 6'b000111;
    localparam logic [5:0] OP_LW    = 6'b001111;
    localparam logic [5:0] OP_SW    = 6'b011111;

    // R-type func codes are 2'b11 followed by the ALU_func encoding.
    localparam logic [1:0] FUNC_HI  = 2'b11;

    localparam logic [3:0] ALU_ADD  = 4'b0000;
    localparam logic [3:0] ALU_SUB  = 4'b0001;
    localparam logic [3:0] ALU_AND  = 4'b0010;
    localparam logic [3:0] ALU_OR   = 4'b0011;
    localparam logic [3:0] ALU_NOT  = 4'b0100;
    localparam logic [3:0] ALU_SRA  = 4'b1000;
    localparam logic [3:0] ALU_SRL  = 4'b1001;
    localparam logic [3:0] ALU_SLL  = 4'b1010;
    localparam logic [3:0] ALU_ROL  = 4'b1100;
    localparam logic [3:0] ALU_ROR  = 4'b1101;

    localparam int MEM_WAIT_MAX = 7;

    typedef enum logic [3:0] {
        S_FETCH,
        S_DECODE,
        S_EXEC_ALU,
        S_WB_ALU,
        S_EXEC_ADDR,
        S_MEM_RD,
        S_WB_MEM,
        S_MEM_WR,
        S_EXEC_BR,
        S_NOP_DONE,
        S_HALT
    } state_e;

    typedef enum logic [1:0] {
        CLS_ALU,
        CLS_MEM,
        CLS_BR,
        CLS_ILL
    } instr_class_e;

    function automatic logic rfunc_legal(input logic [5:0] func);
        if (func[5:4] != FUNC_HI) return 1'b0;
        case (func[3:0])
            ALU_ADD, ALU_SUB, ALU_AND, ALU_OR, ALU_NOT,
            ALU_SRA, ALU_SRL, ALU_SLL, ALU_ROL, ALU_ROR: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/instr_class_decode.sv
// Combinational opcode/func classifier shared by the multicycle and future pipelined control.
module instr_class_decode
    import charis_pkg::*;
(
    input  logic [5:0]   opcode,
    input  logic [5:0]   func,
    output instr_class_e cls,
    output logic [3:0]   alu_func,
    output logic         is_imm,
    output logic         is_byte,
    output logic         is_store,
    output logic         ain_zero,
    output logic         uses_rt,
    output logic         legal
);

    always_comb begin
        cls      = CLS_ILL;
        alu_func = ALU_ADD;
        is_imm   = 1'b0;
        is_byte  = 1'b0;
        is_store = 1'b0;
        ain_zero = 1'b0;
        uses_rt  = 1'b0;
        case (opcode)
            OP_RTYPE: begin
                if (rfunc_legal(func)) begin
                    cls      = CLS_ALU;
                    alu_func = func[3:0];
                end
            end
            OP_LI, OP_LUI: begin
                cls      = CLS_ALU;
                is_imm   = 1'b1;
                ain_zero = 1'b1;
            end
            OP_ADDI: begin
                cls    = CLS_ALU;
                is_imm = 1'b1;
            end
            OP_ANDI: begin
                cls      = CLS_ALU;
                is_imm   = 1'b1;
                alu_func = ALU_AND;
            end
            OP_ORI: begin
                cls      = CLS_ALU;
                is_imm   = 1'b1;
                alu_func = ALU_OR;
            end
            OP_B: begin
                cls      = CLS_BR;
                alu_func = ALU_SUB;
            end
            OP_BEQ, OP_BNE: begin
                cls      = CLS_BR;
                alu_func = ALU_SUB;
                uses_rt  = 1'b1;
            end
            OP_LB: begin
                cls     = CLS_MEM;
                is_byte = 1'b1;
            end
            OP_LW: cls = CLS_MEM;
            OP_SB: begin
                cls      = CLS_MEM;
                is_byte  = 1'b1;
                is_store = 1'b1;
                uses_rt  = 1'b1;
            end
            OP_SW: begin
                cls      = CLS_MEM;
                is_store = 1'b1;
                uses_rt  = 1'b1;
            end
            default: ;
        endcase
    end

    assign legal = (cls != CLS_ILL);

endmodule

// File: rtl/multicycle_control.sv
// Multicycle control FSM for the CHARIS datapath.
// Defining ILLEGAL_TRAP_EN turns illegal instructions into a sticky HALT flagged on Illegal.
module multicycle_control
    import charis_pkg::*;
#(
    parameter int MEM_WAIT = 0
) (
    input  logic        Clk,
    input  logic        Reset,
    input  logic [31:0] Instr,
    input  logic        Zero,
    output logic        Instr_LdEn,
    output logic        RF_B_sel,
    output logic        RF_WrData_sel,
    output logic        RF_WrEn,
    output logic        ALU_Ain_zero,
    output logic        ALU_Bin_sel,
    output logic [3:0]  ALU_func,
    output logic        Mem_WrEn,
    output logic        ByteOp,
    output logic        PC_sel,
    output logic        PC_LdEn,
    output logic        Retire
`ifdef ILLEGAL_TRAP_EN
    ,
    output logic        Illegal
`endif
);

    localparam logic [2:0] WAIT_LAST = (MEM_WAIT > MEM_WAIT_MAX) ? 3'(MEM_WAIT_MAX) : 3'(MEM_WAIT);

`ifdef ILLEGAL_TRAP_EN
    localparam state_e ILLEGAL_NEXT = S_HALT;
`else
    localparam state_e ILLEGAL_NEXT = S_NOP_DONE;
`endif

    state_e       state_q, state_d;
    logic [5:0]   op_q, func_q;
    logic [2:0]   wait_q;
    logic         wait_done;

    instr_class_e cls;
    logic [3:0]   dec_alu_func;
    logic         is_imm, is_byte, is_store, ain_zero, uses_rt, legal;

    // Only opcode and func steer control; register/immediate fields belong to the datapath.
    logic         unused_instr_bits;
    assign unused_instr_bits = ^Instr[25:6];

    instr_class_decode u_decode (
        .opcode   (op_q),
        .func     (func_q),
        .cls      (cls),
        .alu_func (dec_alu_func),
        .is_imm   (is_imm),
        .is_byte  (is_byte),
        .is_store (is_store),
        .ain_zero (ain_zero),
        .uses_rt  (uses_rt),
        .legal    (legal)
    );

    assign wait_done = (wait_q == WAIT_LAST);

    always_ff @(posedge Clk) begin
        if (Reset) begin
            state_q <= S_FETCH;
            op_q    <= '0;
            func_q  <= '0;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            if (state_q == S_FETCH) begin
                op_q   <= Instr[31:26];
                func_q <= Instr[5:0];
            end
            if ((state_q == S_MEM_RD || state_q == S_MEM_WR) && !wait_done)
                wait_q <= wait_q + 3'd1;
            else
                wait_q <= '0;
        end
    end

    // Outputs are forced low during Reset so an interrupted store or writeback never fires.
    always_comb begin
        state_d       = state_q;
        Instr_LdEn    = 1'b0;
        RF_B_sel      = 1'b0;
        RF_WrData_sel = 1'b0;
        RF_WrEn       = 1'b0;
        ALU_Ain_zero  = 1'b0;
        ALU_Bin_sel   = 1'b0;
        ALU_func      = ALU_ADD;
        Mem_WrEn      = 1'b0;
        ByteOp        = 1'b0;
        PC_sel        = 1'b0;
        PC_LdEn       = 1'b0;
        Retire        = 1'b0;
`ifdef ILLEGAL_TRAP_EN
        Illegal       = 1'b0;
`endif
        if (!Reset) begin
            case (state_q)
                S_FETCH: begin
                    Instr_LdEn = 1'b1;
                    state_d    = S_DECODE;
                end
                S_DECODE: begin
                    RF_B_sel = uses_rt;
                    if (!legal) begin
                        state_d = ILLEGAL_NEXT;
                    end else begin
                        case (cls)
                            CLS_ALU: state_d = S_EXEC_ALU;
                            CLS_MEM: state_d = S_EXEC_ADDR;
                            CLS_BR:  state_d = S_EXEC_BR;
                            default: state_d = ILLEGAL_NEXT;
                        endcase
                    end
                end
                S_EXEC_ALU: begin
                    RF_B_sel     = uses_rt;
                    ALU_Bin_sel  = is_imm;
                    ALU_func     = dec_alu_func;
                    ALU_Ain_zero = ain_zero;
                    state_d      = S_WB_ALU;
                end
                S_WB_ALU: begin
                    RF_WrEn = 1'b1;
                    PC_LdEn = 1'b1;
                    Retire  = 1'b1;
                    state_d = S_FETCH;
                end
                S_EXEC_ADDR: begin
                    RF_B_sel    = uses_rt;
                    ALU_Bin_sel = 1'b1;
                    ALU_func    = ALU_ADD;
                    ByteOp      = is_byte;
                    state_d     = is_store ? S_MEM_WR : S_MEM_RD;
                end
                S_MEM_RD: begin
                    ByteOp = is_byte;
                    if (wait_done) state_d = S_WB_MEM;
                end
                S_WB_MEM: begin
                    RF_WrEn       = 1'b1;
                    RF_WrData_sel = 1'b1;
                    PC_LdEn       = 1'b1;
                    Retire        = 1'b1;
                    ByteOp        = is_byte;
                    state_d       = S_FETCH;
                end
                S_MEM_WR: begin
                    RF_B_sel = uses_rt;
                    ByteOp   = is_byte;
                    if (wait_done) begin
                        Mem_WrEn = 1'b1;
                        PC_LdEn  = 1'b1;
                        Retire   = 1'b1;
                        state_d  = S_FETCH;
                    end
                end
                S_EXEC_BR: begin
                    RF_B_sel = uses_rt;
                    ALU_func = dec_alu_func;
                    if (op_q == OP_BEQ)      PC_sel = Zero;
                    else if (op_q == OP_BNE) PC_sel = ~Zero;
                    else                     PC_sel = 1'b1;
                    PC_LdEn  = 1'b1;
                    Retire   = 1'b1;
                    state_d  = S_FETCH;
                end
                S_NOP_DONE: begin
                    PC_LdEn = 1'b1;
                    Retire  = 1'b1;
                    state_d = S_FETCH;
                end
`ifdef ILLEGAL_TRAP_EN
                S_HALT: begin
                    Illegal = 1'b1;
                    state_d = S_HALT;
                end
`endif
                default: state_d = S_FETCH;
            endcase
        end
    end

endmodule

// File: tb/tb_multicycle_control.sv
// Self-checking bench for multicycle_control: per-instruction schedule model plus directed literal checks.
`timescale 1ns/1ps
module tb_multicycle_control;

    localparam int MW = 2;
`ifdef ILLEGAL_TRAP_EN
    localparam bit TRAP = 1'b1;
`else
    localparam bit TRAP = 1'b0;
`endif

    logic        Clk = 1'b0;
    logic        Reset = 1'b1;
    logic [31:0] Instr = '0;
    logic        Zero = 1'b0;
    logic        Instr_LdEn, RF_B_sel, RF_WrData_sel, RF_WrEn, ALU_Ain_zero, ALU_Bin_sel;
    logic [3:0]  ALU_func;
    logic        Mem_WrEn, ByteOp, PC_sel, PC_LdEn, Retire;
`ifdef ILLEGAL_TRAP_EN
    logic        Illegal;
`endif

    multicycle_control #(.MEM_WAIT(MW)) dut (
        .Clk           (Clk),
        .Reset         (Reset),
        .Instr         (Instr),
        .Zero          (Zero),
        .Instr_LdEn    (Instr_LdEn),
        .RF_B_sel      (RF_B_sel),
        .RF_WrData_sel (RF_WrData_sel),
        .RF_WrEn       (RF_WrEn),
        .ALU_Ain_zero  (ALU_Ain_zero),
        .ALU_Bin_sel   (ALU_Bin_sel),
        .ALU_func      (ALU_func),
        .Mem_WrEn      (Mem_WrEn),
        .ByteOp        (ByteOp),
        .PC_sel        (PC_sel),
        .PC_LdEn       (PC_LdEn),
        .Retire        (Retire)
`ifdef ILLEGAL_TRAP_EN
        ,
        .Illegal       (Illegal)
`endif
    );

    always #5 Clk = ~Clk;

    typedef struct packed {
        logic       ldi, bsel, wdsel, wren, azero, binsel;
        logic [3:0] func;
        logic       mwr, byteop, pcsel, pcld, ret, ill;
    } ov_t;

    // brm: -1 fixed PC_sel, 0 always taken, 1 taken on Zero, 2 taken on ~Zero
    typedef struct {
        ov_t v;
        int  brm;
    } ent_t;

    localparam int K_ALU = 0, K_LD = 1, K_ST = 2, K_BR = 3, K_ILL = 4;

    int   total = 0;
    int   bad = 0;
    ent_t sched[$];
    bit   halted = 0, halt_pending = 0, synced = 0;
    ov_t  tr [0:15];

    logic [39:0] lfn = {4'h0, 4'h1, 4'h2, 4'h3, 4'h4, 4'h8, 4'h9, 4'hA, 4'hC, 4'hD};
    logic [5:0]  ops [0:11] = '{6'b111000, 6'b111001, 6'b110000, 6'b110010, 6'b110011, 6'b111111,
                                6'b000000, 6'b000001, 6'b000011, 6'b000111, 6'b001111, 6'b011111};

    function automatic ov_t sample();
        ov_t o;
        o.ldi = Instr_LdEn;    o.bsel = RF_B_sel;   o.wdsel = RF_WrData_sel;
        o.wren = RF_WrEn;      o.azero = ALU_Ain_zero; o.binsel = ALU_Bin_sel;
        o.func = ALU_func;     o.mwr = Mem_WrEn;    o.byteop = ByteOp;
        o.pcsel = PC_sel;      o.pcld = PC_LdEn;    o.ret = Retire;
`ifdef ILLEGAL_TRAP_EN
        o.ill = Illegal;
`else
        o.ill = 1'b0;
`endif
        return o;
    endfunction

    function automatic void classify(input logic [31:0] ins, output int kind, output int brm,
                                     output logic [3:0] f, output logic imm, output logic az,
                                     output logic by, output logic rt);
        logic [5:0] op, fn;
        op = ins[31:26];
        fn = ins[5:0];
        kind = K_ILL; brm = -1; f = 4'h0; imm = 0; az = 0; by = 0; rt = 0;
        case (op)
            6'b100000: if (fn[5:4] == 2'b11 && fn[3:0] inside {4'h0, 4'h1, 4'h2, 4'h3, 4'h4,
                                                                4'h8, 4'h9, 4'hA, 4'hC, 4'hD}) begin
                kind = K_ALU; f = fn[3:0];
            end
            6'b111000, 6'b111001: begin kind = K_ALU; imm = 1; az = 1; end
            6'b110000: begin kind = K_ALU; imm = 1; end
            6'b110010: begin kind = K_ALU; imm = 1; f = 4'h2; end
            6'b110011: begin kind = K_ALU; imm = 1; f = 4'h3; end
            6'b111111: begin kind = K_BR; brm = 0; end
            6'b000000: begin kind = K_BR; brm = 1; rt = 1; end
            6'b000001: begin kind = K_BR; brm = 2; rt = 1; end
            6'b000011: begin kind = K_LD; by = 1; end
            6'b001111: kind = K_LD;
            6'b000111: begin kind = K_ST; by = 1; rt = 1; end
            6'b011111: begin kind = K_ST; rt = 1; end
            default: ;
        endcase
    endfunction

    function automatic void push(input ov_t v, input int b);
        ent_t e;
        e.v = v;
        e.brm = b;
        sched.push_back(e);
    endfunction

    // Builds the per-cycle output schedule for one instruction, from DECODE to completion.
    function automatic void build(input logic [31:0] ins);
        int kind, brm;
        logic [3:0] f;
        logic imm, az, by, rt;
        ov_t v;
        classify(ins, kind, brm, f, imm, az, by, rt);
        v = '0; v.bsel = rt; push(v, -1);
        case (kind)
            K_ALU: begin
                v = '0; v.binsel = imm; v.func = f; v.azero = az; push(v, -1);
                v = '0; v.wren = 1; v.pcld = 1; v.ret = 1; push(v, -1);
            end
            K_LD: begin
                v = '0; v.binsel = 1; v.byteop = by; push(v, -1);
                for (int i = 0; i <= MW; i++) begin v = '0; v.byteop = by; push(v, -1); end
                v = '0; v.wren = 1; v.wdsel = 1; v.pcld = 1; v.ret = 1; v.byteop = by; push(v, -1);
            end
            K_ST: begin
                v = '0; v.binsel = 1; v.byteop = by; v.bsel = 1; push(v, -1);
                for (int i = 0; i < MW; i++) begin v = '0; v.byteop = by; v.bsel = 1; push(v, -1); end
                v = '0; v.byteop = by; v.bsel = 1; v.mwr = 1; v.pcld = 1; v.ret = 1; push(v, -1);
            end
            K_BR: begin
                v = '0; v.func = 4'h1; v.bsel = rt; v.pcld = 1; v.ret = 1; push(v, brm);
            end
            default: begin
                if (TRAP) halt_pending = 1;
                else begin v = '0; v.pcld = 1; v.ret = 1; push(v, -1); end
            end
        endcase
    endfunction

    function automatic ov_t model_step();
        ent_t e;
        ov_t exp;
        exp = '0;
        if (Reset) begin
            sched.delete();
            halted = 0;
            halt_pending = 0;
        end else if (halted) begin
            exp.ill = 1;
        end else if (sched.size() == 0) begin
            exp.ldi = 1;
            build(Instr);
        end else begin
            e = sched.pop_front();
            exp = e.v;
            if (e.brm == 0)      exp.pcsel = 1'b1;
            else if (e.brm == 1) exp.pcsel = Zero;
            else if (e.brm == 2) exp.pcsel = ~Zero;
            if (sched.size() == 0 && halt_pending) begin
                halted = 1;
                halt_pending = 0;
            end
        end
        return exp;
    endfunction

    always @(negedge Clk) begin
        ov_t exp, act;
        if (Reset) synced = 1;
        if (synced) begin
            exp = model_step();
            act = sample();
            total++;
            if (act !== exp) begin
                bad++;
                $display("FAIL cycle_outputs t=%0t act=%b exp=%b", $time, act, exp);
            end
        end
    end

    task automatic cyc(input logic rst, input logic [31:0] ins, input logic z);
        @(posedge Clk);
        #1;
        Reset = rst;
        Instr = ins;
        Zero  = z;
    endtask

    task automatic run(input logic [31:0] ins, input logic z, input int n, input int rst_at);
        cyc(1'b1, ins, z);
        for (int c = 1; c <= n; c++) begin
            cyc(logic'(c == rst_at), ins, z);
            @(negedge Clk);
            tr[c] = sample();
        end
    endtask

    task automatic chk(input string nm, input int act, input int exp);
        total++;
        if (act != exp) begin
            bad++;
            $display("FAIL %s act=%0d exp=%0d", nm, act, exp);
        end
    endtask

    function automatic logic [31:0] rand_instr();
        logic [31:0] r;
        int k;
        r = $urandom;
        k = int'($urandom_range(0, 15));
        if (k < 3) begin
            r[31:26] = 6'b100000;
            if ($urandom_range(0, 3) == 0) r[5:0] = 6'($urandom);
            else r[5:0] = {2'b11, lfn[4*int'($urandom_range(0, 9)) +: 4]};
        end else if (k < 15) begin
            r[31:26] = ops[k - 3];
        end
        return r;
    endfunction

    initial begin
        int n, m;
        cyc(1'b1, 32'h0, 1'b0);
        @(negedge Clk);
        chk("reset_outputs", int'(sample()), 0);

        // add r3,r1,r2
        run(32'h8022_1830, 1'b0, 5, 0);
        n = 0; m = 0;
        for (int c = 1; c <= 4; c++) begin n += int'(tr[c].wren); m += int'(tr[c].ret); end
        chk("add_fetch_ldi", int'(tr[1].ldi), 1);
        chk("add_wren_c4", int'(tr[4].wren), 1);
        chk("add_wdsel_c4", int'(tr[4].wdsel), 0);
        chk("add_wren_count", n, 1);
        chk("add_retire_count", m, 1);
        chk("add_func_c3", int'(tr[3].func), 0);
        chk("add_next_fetch", int'(tr[5].ldi), 1);

        // or r3,r1,r2 / addi / li
        run(32'h8022_1833, 1'b0, 4, 0);
        chk("or_func_c3", int'(tr[3].func), 3);
        chk("or_binsel_c3", int'(tr[3].binsel), 0);
        run(32'hC022_0005, 1'b0, 4, 0);
        chk("addi_binsel_c3", int'(tr[3].binsel), 1);
        run(32'hE002_0005, 1'b0, 4, 0);
        chk("li_azero_c3", int'(tr[3].azero), 1);

        // lw: memory read holds MW+1 cycles
        run(32'h3C22_0004, 1'b0, 6 + MW, 0);
        n = 0; m = 0;
        for (int c = 1; c <= 5 + MW; c++) begin n += int'(tr[c].wren); m += int'(tr[c].byteop); end
        chk("lw_wren_last", int'(tr[5 + MW].wren), 1);
        chk("lw_wdsel_last", int'(tr[5 + MW].wdsel), 1);
        chk("lw_wren_count", n, 1);
        chk("lw_byteop_count", m, 0);
        chk("lw_next_fetch", int'(tr[6 + MW].ldi), 1);

        // sb
        run(32'h1C22_0008, 1'b0, 5 + MW, 0);
        n = 0; m = 0;
        for (int c = 1; c <= 4 + MW; c++) begin n += int'(tr[c].mwr); m += int'(tr[c].wren); end
        chk("sb_mwr_last", int'(tr[4 + MW].mwr), 1);
        chk("sb_byteop_last", int'(tr[4 + MW].byteop), 1);
        chk("sb_bsel_last", int'(tr[4 + MW].bsel), 1);
        chk("sb_mwr_count", n, 1);
        chk("sb_wren_count", m, 0);

        // branches
        run(32'h0022_0010, 1'b1, 3, 0);
        chk("beq_z1_pcsel", int'(tr[3].pcsel), 1);
        chk("beq_z1_pcld", int'(tr[3].pcld), 1);
        run(32'h0422_0010, 1'b1, 3, 0);
        chk("bne_z1_pcsel", int'(tr[3].pcsel), 0);
        run(32'hFC00_0010, 1'b0, 3, 0);
        chk("b_z0_pcsel", int'(tr[3].pcsel), 1);

        // sw interrupted by Reset in the cycle that would write memory
        run(32'h7C22_0004, 1'b0, 5 + MW, 4 + MW);
        n = 0;
        for (int c = 1; c <= 5 + MW; c++) n += int'(tr[c].mwr);
        chk("sw_rst_outputs", int'(tr[4 + MW]), 0);
        chk("sw_rst_mwr_count", n, 0);
        chk("sw_rst_fetch", int'(tr[5 + MW].ldi), 1);

        // illegal opcode and illegal R-type func
        for (int t = 0; t < 2; t++) begin
            run((t == 0) ? 32'hA800_0000 : 32'h8022_183F, 1'b0, 6, 0);
            n = 0; m = 0;
            for (int c = 3; c <= 6; c++) begin n += int'(tr[c].ill); m += int'(tr[c].pcld); end
`ifdef ILLEGAL_TRAP_EN
            chk("ill_halt_flag", n, 4);
            chk("ill_halt_pcld", m, 0);
`else
            chk("ill_nop_pcld", int'(tr[3].pcld), 1);
            chk("ill_nop_retire", int'(tr[3].ret), 1);
            chk("ill_nop_fetch", int'(tr[4].ldi), 1);
`endif
        end

        // randomized traffic, Instr changes every cycle to exercise the latch
        cyc(1'b1, 32'h0, 1'b0);
        for (int i = 0; i < 3000; i++)
            cyc(logic'($urandom_range(0, 39) == 0), rand_instr(), 1'($urandom_range(0, 1)));
        cyc(1'b0, 32'h0, 1'b0);
        @(negedge Clk);
        #1;
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/multicycle_control.md
Name: multicycle_control

Overview:
- Multicycle control FSM for the CHARIS-style datapath.
- Latches the fetched instruction and drives the control signals the decode stage and datapath consume: RF_WrEn, RF_WrData_sel, RF_B_sel, ALU operand/function selects, memory write, PC update.
- Sits between instruction memory and the DECSTAGE/EXSTAGE/MEMSTAGE datapath.
- Producer end of the decode-stage control interface.

Parameters:
- MEM_WAIT, 0, extra wait cycles inserted in each memory-access state (0..7).

Ports:
- Clk  in  1  clock
- Reset  in  1  synchronous active-high reset
- Instr  in  32  instruction from instruction memory
- Zero  in  1  ALU zero flag
- Instr_LdEn  out  1  instruction register load enable
- RF_B_sel  out  1  0: read reg Instr[15:11]; 1: read reg Instr[20:16]
- RF_WrData_sel  out  1  0: ALU_out; 1: MEM_out
- RF_WrEn  out  1  register file write enable
- ALU_Ain_zero  out  1  force ALU A operand to 0
- ALU_Bin_sel  out  1  0: RF_B; 1: Immed
- ALU_func  out  4  ALU operation
- Mem_WrEn  out  1  data memory write enable
- ByteOp  out  1  byte access (lb/sb)
- PC_sel  out  1  0: PC+4; 1: PC+4+Immed
- PC_LdEn  out  1  PC load enable
- Retire  out  1  one-cycle pulse per completed instruction

Behaviour:
- Opcodes: R-type 100000 (func = Instr[5:0]); li 111000, lui 111001, addi 110000, andi 110010, ori 110011, b 111111, beq 000000, bne 000001, lb 000011, sb 000111, lw 001111, sw 011111.
- ALU_func encodings: add 0000, sub 0001, and 0010, or 0011, not 0100, sra 1000, srl 1001, sll 1010, rol 1100, ror 1101.
- R-type ALU_func = func[3:0]. Any func outside the list above is illegal.
- The opcode and func are captured in an internal register in FETCH. All later states decode that register, not the live Instr.
- States:
  - FETCH: Instr_LdEn=1 → DECODE.
  - DECODE: RF_B_sel valid.
    - ALU ops, li, lui → EXEC_ALU.
    - lb, lw, sb, sw → EXEC_ADDR.
    - beq, bne, b → EXEC_BR.
    - illegal → NOP_DONE.
  - EXEC_ALU: ALU_Bin_sel=1 for I-type, 0 for R-type.
    - ALU_func: add for addi/li/lui, and for andi, or for ori.
    - ALU_Ain_zero=1 for li/lui.
    - → WB_ALU.
  - WB_ALU: RF_WrEn=1, RF_WrData_sel=0, PC_LdEn=1, PC_sel=0, Retire=1 → FETCH.
  - EXEC_ADDR: ALU add, ALU_Bin_sel=1. → MEM_RD for loads, MEM_WR for stores.
  - MEM_RD: holds MEM_WAIT+1 cycles (wait counter) → WB_MEM.
  - WB_MEM: RF_WrEn=1, RF_WrData_sel=1, PC_LdEn=1, PC_sel=0, Retire=1 → FETCH.
  - MEM_WR: holds MEM_WAIT+1 cycles. Mem_WrEn=1 on the last cycle only, together with PC_LdEn=1, PC_sel=0, Retire=1 → FETCH.
  - EXEC_BR: ALU sub, ALU_Bin_sel=0, RF_B_sel=1.
    - PC_sel = Zero (beq), ~Zero (bne), 1 (b). Combinational on Zero.
    - PC_LdEn=1, Retire=1 → FETCH.
  - NOP_DONE: PC_LdEn=1, PC_sel=0, Retire=1 → FETCH.
- ByteOp=1 in EXEC_ADDR/MEM_*/WB_MEM for lb/sb; otherwise 0.
- RF_B_sel=1 from DECODE through completion for sw, sb, beq, bne; otherwise 0.
- Latency (MEM_WAIT=0): ALU/li/lui 4 cycles, loads 5, stores 4, branches 3, illegal 3.
- All outputs not named in a state are 0.
- Reset, including mid-instruction: next state FETCH, wait counter 0, opcode register 0, all outputs 0 in the reset cycle. No partial RF or memory write is allowed in the cycle after Reset is asserted.
- RF_WrEn, Mem_WrEn and PC_LdEn never assert in the same cycle as Reset.

Optional Feature:
- Macro ILLEGAL_TRAP_EN.
- Defined:
  - An illegal opcode or func enters HALT instead of NOP_DONE.
  - HALT asserts all outputs 0 and adds a 1-bit output Illegal, held 1.
  - HALT is exited only by Reset.
- Undefined: no Illegal port; illegal instructions are 3-cycle no-ops that advance the PC.

Decomposition:
- Package charis_pkg holds:
  - opcode and func constants
  - ALU_func encodings
  - FSM state enumeration
  - MEM_WAIT range limit
- One natural sub-module: instr_class_decode. It is combinational and maps opcode/func to {class, ALU_func, is_imm, is_byte, legal}, shared with future pipelined control.

Test Plan:
- Instr=add r3,r1,r2 (0x80221830), Reset released → FETCH..WB_ALU. RF_WrEn=1, RF_WrData_sel=0 in cycle 4 only. ALU_func=0000. Retire once.
- lw (0x3C22_0004), MEM_WAIT=2 → MEM_RD lasts 3 cycles. RF_WrEn with RF_WrData_sel=1 in cycle 7. ByteOp=0.
- sb (0x1C22_0008) → Mem_WrEn=1, ByteOp=1, RF_B_sel=1 in exactly one cycle (4). RF_WrEn never 1.
- beq with Zero=1 → PC_sel=1, PC_LdEn=1 in cycle 3. bne with Zero=1 → PC_sel=0. b → PC_sel=1 regardless of Zero.
- Reset asserted during MEM_WR wait (MEM_WAIT=3) → no Mem_WrEn pulse. FETCH with Instr_LdEn=1 in the first cycle after Reset deasserts.
- Opcode 0x2A, R-type func 0x3F → 3-cycle no-op with Retire. With ILLEGAL_TRAP_EN: Illegal=1 stays high, PC_LdEn stays 0 until Reset.
